// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word requests to
// instruction memory and buffers each returned instruction until decode takes it.
module instr_fetch #(
  parameter int ARQ = 16,
  parameter int AW  = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pc_en,
  input  logic           jenable,
  input  logic [AW-1:0]  jaddr,
  output logic           imem_req,
  output logic [AW-1:0]  imem_addr,
  input  logic           imem_valid,
  input  logic [ARQ-1:0] imem_data,
  input  logic           id_ready,
  output logic [ARQ-1:0] instr,
  output logic           instr_valid,
  output logic [AW-1:0]  pc_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           squash_q, squash_d;
  logic [ARQ-1:0] instr_q, instr_d;
  logic [AW-1:0]  pc_out_q, pc_out_d;
  logic           valid_q, valid_d;
  logic           launch;

  // The request address lives in its own register because a jump taken while a
  // request is outstanding moves the PC but must leave imem_addr untouched.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    squash_d = squash_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    launch   = 1'b0;

    if (jenable) pc_d = jaddr;

    unique case (state_q)
      IDLE: begin
        if (pc_en) begin
          state_d = BUSY;
          launch  = 1'b1;
        end
      end

      BUSY: begin
        if (imem_valid) begin
          if (squash_q || jenable) begin
            // Wrong-path response: drop it and restart at the (possibly new) PC.
            squash_d = 1'b0;
            state_d  = pc_en ? BUSY : IDLE;
            launch   = pc_en;
          end else begin
            instr_d  = imem_data;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + AW'(1);
            state_d  = FULL;
          end
        end else if (jenable) begin
          squash_d = 1'b1;
        end
      end

      FULL: begin
        if (jenable || id_ready) begin
          valid_d = 1'b0;
          state_d = pc_en ? BUSY : IDLE;
          launch  = pc_en;
        end
      end

      default: state_d = IDLE;
    endcase

    if (launch) addr_d = pc_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      addr_q   <= '0;
      squash_q <= 1'b0;
      // NOTE: the one-entry buffer is reset too, so instr/pc_out read 0 out
      // of reset instead of stale or undefined contents.
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      squash_q <= squash_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  // Memory-side outputs come from registered state only.
  assign imem_req    = (state_q == BUSY);
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: random-latency memory model, directed
// scenarios, then random stimulus checked against a program-order scoreboard.
module tb_instr_fetch;
  localparam int ARQ = 16;
  localparam int AW  = 13;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pc_en = 1'b0;
  logic           jenable = 1'b0;
  logic [AW-1:0]  jaddr = '0;
  logic           imem_req;
  logic [AW-1:0]  imem_addr;
  logic           imem_valid = 1'b0;
  logic [ARQ-1:0] imem_data = '0;
  logic           id_ready = 1'b0;
  logic [ARQ-1:0] instr;
  logic           instr_valid;
  logic [AW-1:0]  pc_out;

  int n_cmp = 0;
  int n_fail = 0;
  int lat_mode = 0;      // fixed memory latency, or -1 for random 0..3
  bit rate_chk = 1'b0;   // enables the one-entry-per-2-cycles check
  int deliveries = 0;

  // memory model state
  bit            m_busy = 1'b0;
  int            m_cnt = 0;
  logic [AW-1:0] m_addr = '0;

  // scoreboard / monitor state
  logic [AW-1:0]  exp_q[$];
  logic [AW-1:0]  e_pc, e_next;
  bit             p_req = 1'b0, p_acc = 1'b0, p_hold = 1'b0;
  logic [ARQ-1:0] p_instr = '0;
  logic [AW-1:0]  p_pc = '0, p_addr = '0;
  int             cyc = 0, last_del = -1;

  instr_fetch #(.ARQ(ARQ), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_en      (pc_en),
    .jenable    (jenable),
    .jaddr      (jaddr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .id_ready   (id_ready),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [ARQ-1:0] mem_word(input logic [AW-1:0] a);
    return 16'hA000 | 16'(a);
  endfunction

  // Instruction memory: answers each request after lat_mode wait cycles; while
  // reset is held it drives garbage responses that must be ignored.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        imem_valid = 1'($urandom);
        imem_data  = 16'($urandom);
        m_busy     = 1'b0;
      end else if (!imem_req) begin
        imem_valid = 1'b0;
        m_busy     = 1'b0;
      end else begin
        if (imem_valid) m_busy = 1'b0;  // previous response was taken at the last edge
        if (!m_busy) begin
          m_busy = 1'b1;
          m_addr = imem_addr;
          m_cnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end
        if (m_cnt == 0) begin
          imem_valid = 1'b1;
          imem_data  = mem_word(m_addr);
        end else begin
          imem_valid = 1'b0;
          m_cnt--;
        end
      end
    end
  end

  // Monitor: samples just before each rising edge. The reference model is the
  // program-order stream: consecutive addresses, restarted at each jump target.
  initial begin
    exp_q.push_back('0);
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst) begin
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_imem_addr", 32'(imem_addr), 32'd0);
        check("reset_instr_valid", 32'(instr_valid), 32'd0);
        check("reset_instr", 32'(instr), 32'd0);
        check("reset_pc_out", 32'(pc_out), 32'd0);
        exp_q.delete();
        exp_q.push_back('0);
        p_req = 1'b0; p_acc = 1'b0; p_hold = 1'b0; last_del = -1;
      end else begin
        check("one_outstanding", 32'(imem_req & instr_valid), 32'd0);
        if (!p_req && imem_req) check("req_addr", 32'(imem_addr), 32'(exp_q[0]));
        if (p_req && !p_acc && imem_req) check("addr_stable", 32'(imem_addr), 32'(p_addr));
        if (p_hold) begin
          check("hold_valid", 32'(instr_valid), 32'd1);
          check("hold_instr", 32'(instr), 32'(p_instr));
          check("hold_pc_out", 32'(pc_out), 32'(p_pc));
        end
        if (jenable) begin
          exp_q.delete();
          exp_q.push_back(jaddr);
        end else if (instr_valid && id_ready) begin
          check("sb_not_empty", 32'(exp_q.size()), 32'd1);
          if (exp_q.size() > 0) begin
            e_pc = exp_q.pop_front();
            check("pc_out", 32'(pc_out), 32'(e_pc));
            check("instr", 32'(instr), 32'(mem_word(e_pc)));
            e_next = e_pc + 13'd1;
            exp_q.push_back(e_next);
          end
          deliveries++;
          if (rate_chk && last_del >= 0) check("throughput_gap", 32'(cyc - last_del), 32'd2);
          last_del = cyc;
        end
        if (!rate_chk) last_del = -1;
        p_hold  = instr_valid && !id_ready && !jenable;
        p_instr = instr;
        p_pc    = pc_out;
        p_acc   = imem_req && imem_valid;
        p_req   = imem_req;
        p_addr  = imem_addr;
      end
    end
  end

  task automatic wait_entry(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (instr_valid) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_req_addr(input logic [AW-1:0] a, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (imem_req && imem_addr == a) break;
      @(negedge clk);
    end
  endtask

  int d0;

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b0;
    #2;
    check("async_reset_req", 32'(imem_req), 32'd0);
    check("async_reset_valid", 32'(instr_valid), 32'd0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_req", 32'(imem_req), 32'd0);

    // Sequential zero-wait fetch: one entry every 2 cycles.
    lat_mode = 0; pc_en = 1'b1; id_ready = 1'b1; rate_chk = 1'b1;
    d0 = deliveries;
    repeat (12) @(negedge clk);
    rate_chk = 1'b0;
    check("seq_count_ge4", 32'(deliveries - d0 >= 4), 32'd1);

    // Backpressure: decode stalls for 5 cycles while the buffer is full.
    lat_mode = 1; id_ready = 1'b0;
    wait_entry(20);
    check("bp_entry_present", 32'(instr_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_no_req", 32'(imem_req), 32'd0);
    end
    id_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Reset while a 3-cycle request is outstanding.
    lat_mode = 3;
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    check("busy_before_reset", 32'(imem_req), 32'd1);
    #2 rst = 1'b0;
    #1 check("reset_drops_req", 32'(imem_req), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Jump one cycle after the request to address 2 rises.
    wait_req_addr(13'd2, 40);
    check("req_addr2_seen", 32'(imem_addr), 32'd2);
    jenable = 1'b1; jaddr = 13'h0100;
    @(negedge clk);
    jenable = 1'b0;
    wait_entry(30);
    check("jump_entry_valid", 32'(instr_valid), 32'd1);
    check("jump_pc_out", 32'(pc_out), 32'h0100);
    check("jump_instr", 32'(instr), 32'hA100);

    // Wrap-around at the top of the address space.
    lat_mode = -1;
    @(negedge clk);
    jenable = 1'b1; jaddr = 13'h1FFF;
    @(negedge clk);
    jenable = 1'b0;
    wait_entry(30);
    check("wrap_first", 32'(pc_out), 32'h1FFF);
    @(negedge clk);
    wait_entry(30);
    check("wrap_second", 32'(pc_out), 32'h0000);
    check("wrap_second_valid", 32'(instr_valid), 32'd1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      pc_en    = ($urandom % 8) != 0;
      id_ready = ($urandom % 5) < 3;
      jenable  = ($urandom % 25) == 0;
      jaddr    = (($urandom % 4) == 0) ? 13'h1FFF - 13'($urandom_range(0, 2)) : 13'($urandom);
    end
    @(negedge clk);
    jenable = 1'b0; pc_en = 1'b0; id_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("quiesce_idle_req", 32'(imem_req), 32'd0);
    check("quiesce_empty", 32'(instr_valid), 32'd0);
    check("enough_deliveries", 32'(deliveries >= 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit pipelined core: the producer side of the decode stage's instruction input. It owns the program counter and issues word requests to instruction memory over a req/valid handshake. It holds each returned instruction in a one-entry buffer until decode accepts it. It applies jump redirects (enable plus 13-bit target) and squashes any instruction fetched on the wrong path.

## Interface
- ARQ, 16, instruction width
- AW, 13, PC and instruction-memory address width (word addressed)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_en  in  1  fetch enable; 0 = issue no new requests
- jenable  in  1  jump redirect, single-cycle pulse
- jaddr  in  AW  jump target, sampled when jenable=1
- imem_req  out  1  request valid; imem_addr held stable while high
- imem_addr  out  AW  word address of the request
- imem_valid  in  1  response valid; counts only while imem_req=1
- imem_data  in  ARQ  instruction word, valid with imem_valid
- id_ready  in  1  decode accepts instr this cycle
- instr  out  ARQ  buffered instruction to decode
- instr_valid  out  1  instr/pc_out hold a valid entry
- pc_out  out  AW  address that instr was fetched from

## Operation
- Registered state:
  - pc (AW)
  - FSM state ∈ {IDLE, BUSY, FULL}
  - squash flag
  - instr, pc_out, instr_valid
- IDLE:
  - imem_req=0, buffer empty.
  - pc_en=1 → BUSY.
- BUSY:
  - imem_req=1, imem_addr=pc.
  - Response is accepted in any cycle with imem_valid=1, including the cycle imem_req first rises (zero-wait memory).
  - On acceptance with squash=0 and no jenable: instr←imem_data, pc_out←pc, instr_valid←1, pc←pc+1, state→FULL.
  - On acceptance with squash=1 or jenable=1: data is discarded and squash←0. State→BUSY if pc_en=1, else IDLE.
- FULL:
  - imem_req=0, instr_valid=1; instr and pc_out are held constant.
  - On id_ready=1: instr_valid←0, state→BUSY if pc_en=1, else IDLE.
  - On id_ready=0: stay in FULL.
- Jump (jenable=1) has priority over all other events in the same cycle:
  - pc←jaddr; instr_valid←0 (buffered entry flushed, even if id_ready=1).
  - BUSY without imem_valid: squash←1. The request stays at the old address until its response arrives, then that response is discarded and a new request issues at jaddr.
  - BUSY with imem_valid: response discarded as above, no squash set.
  - FULL: state→BUSY if pc_en=1, else IDLE.
  - IDLE: only pc updates.
  - A second jump while squash=1 only updates pc.
- pc_en=0 never aborts an outstanding request. The response completes into FULL; after it is consumed the FSM goes to IDLE.
- PC arithmetic is modulo 2^AW: 0x1FFF+1 = 0x0000.
- At most one request is outstanding. A request issues only when the buffer is empty, so acceptance never overwrites a valid entry.

## Timing
- Reset (async assert, no clock needed): pc=0, state=IDLE, squash=0, imem_req=0, imem_addr=0, instr=0, instr_valid=0, pc_out=0.
- imem_valid arriving after reset asserts is ignored.
- imem_req and imem_addr are decoded from registered state only, with no combinational path from inputs.
- Latency with zero-wait memory:
  - Edge E0 with pc_en=1 in IDLE → BUSY; imem_req high after E0.
  - imem_valid in that cycle → instr_valid high after E1.
  - id_ready consumed at E2 → next request after E2.
  - Throughput is one instruction per 2 cycles.
- With N-cycle memory latency, instr_valid rises on the edge that samples imem_valid.
- Jump-to-new-request latency:
  - 1 cycle from IDLE or FULL.
  - From BUSY, 1 cycle after the stale response arrives.

## Test plan
- Reset: hold rst=0 and toggle imem_valid → all outputs 0, no state change; release → IDLE, imem_req=0 until pc_en=1.
- Sequential fetch: zero-wait memory returns imem_data = 0xA000 | addr; pc_en=1, id_ready=1 → instr 0xA000, 0xA001, 0xA002 with pc_out 0, 1, 2, one entry every 2 cycles.
- Backpressure: id_ready=0 for 5 cycles while FULL → instr and pc_out constant, imem_req=0; id_ready=1 → next imem_addr = pc_out+1.
- Jump during a 3-cycle-latency request: jenable with jaddr=0x0100 one cycle after req to addr 2 → addr-2 data never reaches instr; next imem_addr=0x0100, then instr_valid with pc_out=0x0100.
- Wrap: jump to 0x1FFF, fetch two entries → pc_out 0x1FFF, then 0x0000.
- Reset mid-BUSY: drop rst between edges → imem_req falls immediately; later imem_valid is ignored, and after release the first fetch is at address 0.
